elastic_fifo_dv: RTL
====================

Name: elastic_fifo_dv

Overview:
- Multi-slot elastic FIFO with data, valid and ready, placed directly downstream of the pipelined float units (subf/addf).
- Absorbs the result stream from the unit's output handshake when the consumer stalls, so the unit's ce/ready path does not need to stall as often.
- Breaks the combinational data/valid path and the ready path between the float unit and its consumer.
- Uses the standard dataflow handshake: a transfer happens on a cycle where valid and ready are both 1.

Parameters:
- DATA_TYPE, 32: payload width in bits; must be ≥1.
- NUM_SLOTS, 4: storage depth; must be ≥2; any integer, not only powers of two.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ins  in  DATA_TYPE  payload from upstream (e.g. the subf result).
- ins_valid  in  1  upstream payload is valid.
- ins_ready  out  1  FIFO can accept a payload this cycle.
- outs  out  DATA_TYPE  head payload.
- outs_valid  out  1  head payload is valid.
- outs_ready  in  1  downstream accepts the head this cycle.

Behaviour:
- State: memory of NUM_SLOTS words; head and tail pointers of width clog2(NUM_SLOTS); occupancy counter of width clog2(NUM_SLOTS+1).
- Derived flags: empty = (count==0); full = (count==NUM_SLOTS).
- Outputs are functions of registers only (no input-to-output combinational path):
  - ins_ready = !full
  - outs_valid = !empty
  - outs = mem[head]
- Push = ins_valid && ins_ready. On push: mem[tail] <= ins; tail <= (tail==NUM_SLOTS-1) ? 0 : tail+1.
- Pop = outs_valid && outs_ready. On pop: head advances with the same wrap rule.
- Counter update: count += push − pop.
  - Push and pop together: count unchanged; both pointers advance.
- Latency: a word pushed in cycle N appears on outs at cycle N+1 at the earliest, when the FIFO was empty. There is no same-cycle bypass.
- Throughput: 1 word per cycle sustained while 0 < count < NUM_SLOTS.
- Full:
  - ins_ready = 0 even if outs_ready = 1 in the same cycle. The ready path is deliberately not combinational.
  - A pop in that cycle frees a slot, so ins_ready = 1 next cycle.
- Empty:
  - outs_valid = 0 and outs is don't-care.
  - A pop cannot occur because outs_valid = 0.
  - A push makes outs_valid = 1 next cycle.
- Wrap-around: pointers wrap from NUM_SLOTS-1 to 0. Non-power-of-two depths must wrap correctly and never address index ≥ NUM_SLOTS.
- Ordering: strict FIFO; no word is lost or duplicated.
- Data-holding rule: while outs_valid=1 and outs_ready=0, outs and outs_valid must hold stable.
- Reset (rst=1 at a clock edge): head=0, tail=0, count=0. From the next cycle: outs_valid=0, ins_ready=1.
  - Memory contents are not reset; outs is don't-care after reset.
  - Reset mid-operation discards all stored words. A push requested in the reset cycle is ignored.
- Handshake assumption (assertion, not logic): upstream keeps ins_valid and ins stable until accepted.

Decomposition:
- Shared package holds:
  - a clog2 helper function for pointer and counter widths;
  - the wrap-increment function, reused by other buffers (tehb/oehb variants with slots).
- One natural sub-module: fifo_ptr_ctrl. It holds head, tail and count and produces full, empty, push and pop.
- The top level holds the memory array and the output mux.

Test Plan:
- Basic pass-through: rst for 2 cycles, then push 0x3F800000 with outs_ready=1 → outs_valid=1 one cycle later with outs=0x3F800000; then empty, outs_valid=0.
- Fill to full: NUM_SLOTS=4, outs_ready=0, push 0x1,0x2,0x3,0x4 → ins_ready=0 after the 4th push; a 5th word 0x5 held on ins is not accepted while full.
- Full plus pop: from the full state, set outs_ready=1 → pop 0x1 that cycle, ins_ready still 0 that cycle; next cycle ins_ready=1 and 0x5 is accepted. The drained order is 0x2,0x3,0x4,0x5.
- Simultaneous push/pop with wrap: NUM_SLOTS=3, random ins_valid/outs_ready over 200 cycles with an incrementing payload → the output sequence is strictly incrementing and gap-free, and the pointers never exceed 2.
- Backpressure stability: outs_valid=1 with outs_ready=0 for 5 cycles → outs and outs_valid stay constant across all 5 cycles.
- Reset mid-operation: with 3 words stored, assert rst for 1 cycle while ins_valid=1 → the next cycle has outs_valid=0 and ins_ready=1, and none of the old words or the reset-cycle word ever appear on outs.

Source files
------------

// File: rtl/elastic_fifo_dv_pkg.sv
// Shared definitions for the slot-based elastic buffers placed after the float units.
// Width and wrap helpers are reused by the tehb/oehb slot variants.
package elastic_fifo_dv_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   // Bits needed to encode 0 .. value-1.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

   // Circular increment that also works for depths that are not powers of two.
   function automatic int wrap_inc(input int ptr, input int slots);
      return (ptr == slots - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/elastic_fifo_dv_fifo_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the elastic FIFO; flags come straight
// from the count register so neither ready nor valid has an input-to-output path.
module elastic_fifo_dv_fifo_ptr_ctrl
   import elastic_fifo_dv_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int PTR_W     = 2,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_ins_valid,
   input  logic             i_outs_ready,
   output logic             o_push,
   output logic             o_full,
   output logic             o_empty,
   output logic [PTR_W-1:0] o_head,
   output logic [PTR_W-1:0] o_tail
);

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic     w_full;
   logic     w_empty;
   logic     w_push;
   logic     w_pop;
   fifo_op_e w_op;

   assign w_full  = (r_count == CNT_W'(NUM_SLOTS));
   assign w_empty = (r_count == '0);

   // A full FIFO refuses input even if a pop frees a slot this same cycle.
   assign w_push = i_ins_valid && !w_full;
   assign w_pop  = i_outs_ready && !w_empty;
   assign w_op   = fifo_op_e'({w_push, w_pop});

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= PTR_W'(wrap_inc(int'(r_tail), NUM_SLOTS));
         end
         if (w_pop) begin
            r_head <= PTR_W'(wrap_inc(int'(r_head), NUM_SLOTS));
         end
         case (w_op)
            OP_PUSH: r_count <= r_count + CNT_W'(1);
            OP_POP:  r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_push  = w_push;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_head  = r_head;
   assign o_tail  = r_tail;

endmodule

// File: rtl/elastic_fifo_dv.sv
// Multi-slot elastic FIFO after the pipelined float units: absorbs results while
// the consumer stalls and cuts both the data/valid path and the ready path.
module elastic_fifo_dv
   import elastic_fifo_dv_pkg::*;
#(
   parameter int DATA_TYPE = 32,
   parameter int NUM_SLOTS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_TYPE-1:0] ins,
   input  logic                 ins_valid,
   output logic                 ins_ready,
   output logic [DATA_TYPE-1:0] outs,
   output logic                 outs_valid,
   input  logic                 outs_ready
);

   localparam int PTR_W = clog2(NUM_SLOTS);
   localparam int CNT_W = clog2(NUM_SLOTS + 1);

   logic [DATA_TYPE-1:0] r_mem [NUM_SLOTS];

   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [PTR_W-1:0] w_head;
   logic [PTR_W-1:0] w_tail;

   elastic_fifo_dv_fifo_ptr_ctrl #(
      .NUM_SLOTS (NUM_SLOTS),
      .PTR_W     (PTR_W),
      .CNT_W     (CNT_W)
   ) u_ptr_ctrl (
      .clk          (clk),
      .rst          (rst),
      .i_ins_valid  (ins_valid),
      .i_outs_ready (outs_ready),
      .o_push       (w_push),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_head       (w_head),
      .o_tail       (w_tail)
   );

   // NOTE: the storage array has no reset; stale words are unreachable once the
   // pointers and count are cleared, so a reset here would only cost flops.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[w_tail] <= ins;
      end
   end

   assign ins_ready  = !w_full;
   assign outs_valid = !w_empty;
   assign outs       = r_mem[w_head];

endmodule
